div_arbiter: RTL and testbench
==============================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter NUM_REQ, default 4, number of requesters sharing one divider; range 2..8.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, maximum cycles WAIT tolerates before declaring a timeout.
REQ-004 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_in  input  1  synchronous, active-high reset.
REQ-006 req_valid_in  input  NUM_REQ  per-requester level request; held until that requester's req_ready_out pulse.
REQ-007 req_dividend_in, req_divisor_in  input  NUM_REQ x WIDTH  per-requester operands; stable while req_valid_in is high.
REQ-008 req_ready_out  output  NUM_REQ  one-hot, one-cycle accept pulse; operands captured that cycle.
REQ-009 resp_valid_out  output  NUM_REQ  one-hot, one-cycle result pulse to the originating requester.
REQ-010 resp_quotient_out, resp_remainder_out  output  WIDTH  shared result buses, valid with resp_valid_out.
REQ-011 resp_error_out  output  1  divide-by-zero or timeout, valid with resp_valid_out.
REQ-012 div_dividend_out, div_divisor_out  output  WIDTH  operands to the shared divider.
REQ-013 div_valid_out  output  1  one-cycle start pulse to the divider.
REQ-014 div_quotient_in, div_remainder_in  input  WIDTH  divider results.
REQ-015 div_valid_in, div_error_in, div_busy_in  input  1  divider done pulse, error flag, busy level.
REQ-016 timeout_out  output  1  sticky flag; set on any timeout, cleared only by reset.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP; IDLE after reset.
REQ-018 IDLE: if any req_valid_in is high and div_busy_in is low, grant one requester, pulse its req_ready_out, register its operands and its index, and go to ISSUE the next cycle.
REQ-019 Grant is round-robin: search starts at (last granted index + 1) mod NUM_REQ; the last-granted pointer resets to NUM_REQ-1, so requester 0 wins first.
REQ-020 ISSUE: drive registered operands on div_*_out, assert div_valid_out for exactly this one cycle, clear the timeout counter, and go to WAIT.
REQ-021 WAIT: on div_valid_in, register quotient, remainder and div_error_in, and go to RESP.
REQ-022 WAIT: the counter increments each cycle; when it reaches TIMEOUT_CYCLES without div_valid_in, register quotient=0, remainder=0, error=1, set timeout_out, and go to RESP.
REQ-023 RESP: assert resp_valid_out[granted index] for exactly one cycle with registered results, then go to IDLE.
REQ-024 Service latency is grant cycle + 1 (ISSUE) + divider latency + 1 (RESP); no new grant is issued before IDLE is re-entered.
REQ-025 div_valid_in arriving in IDLE, ISSUE or RESP (for example, a late result after a timeout) is discarded.
REQ-026 div_valid_in arriving on the same cycle the counter reaches TIMEOUT_CYCLES takes priority as a normal result.
REQ-027 req_ready_out, resp_valid_out and div_valid_out are never asserted together in one cycle; at most one bit of each is high.
REQ-028 A requester dropping req_valid_in before it is granted is legal; it is simply not granted.
REQ-029 The block does no arithmetic on operands; results and errors pass through unchanged.

Reset
REQ-030 While rst_in is high, all outputs are 0 and the FSM, counter, registered operands, index and results are cleared.
REQ-031 Reset mid-operation abandons the transaction with no response; after reset, IDLE waits for div_busy_in low before granting.

Structure
REQ-032 Shared package div_pkg holds the FSM state enum and the default WIDTH/NUM_REQ constants.
REQ-033 Round-robin selection is one sub-module, rr_picker (request vector plus pointer in; one-hot grant and index out; combinational).

Verification
REQ-034 Single request: requester 2 sends 100/7 -> one req_ready_out[2] pulse, one div_valid_out pulse, then resp_valid_out[2] with quotient 14, remainder 2, error 0.
REQ-035 All four requesters held high from reset -> grant order 0,1,2,3,0, with each resp_valid_out matching its own operands.
REQ-036 Divisor 0 from requester 1, with the model divider raising error -> resp_valid_out[1], error 1, quotient 0, remainder 0.
REQ-037 Model divider never answers -> resp_valid_out with error 1 exactly TIMEOUT_CYCLES cycles after ISSUE, and timeout_out high; a late div_valid_in is ignored and the next grant waits for div_busy_in low.
REQ-038 rst_in pulsed during WAIT -> no resp_valid_out, all outputs 0, and a subsequent request completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and default sizing for the divider arbiter.
package div_pkg;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NUM_REQ = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: search begins one past the last winner.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!any && req[(int'(last) + k) % NUM_REQ]) begin
        any = 1'b1;
        grant[(int'(last) + k) % NUM_REQ] = 1'b1;
        idx = IDX_W'((int'(last) + k) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/div_arbiter.sv
// Shares one divider among NUM_REQ requesters, one transaction at a time,
// with round-robin grant and a WAIT timeout.
module div_arbiter
  import div_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [NUM_REQ-1:0]              req_valid_in,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_dividend_in,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_divisor_in,
  output logic [NUM_REQ-1:0]              req_ready_out,
  output logic [NUM_REQ-1:0]              resp_valid_out,
  output logic [WIDTH-1:0]                resp_quotient_out,
  output logic [WIDTH-1:0]                resp_remainder_out,
  output logic                            resp_error_out,
  output logic [WIDTH-1:0]                div_dividend_out,
  output logic [WIDTH-1:0]                div_divisor_out,
  output logic                            div_valid_out,
  input  logic [WIDTH-1:0]                div_quotient_in,
  input  logic [WIDTH-1:0]                div_remainder_in,
  input  logic                            div_valid_in,
  input  logic                            div_error_in,
  input  logic                            div_busy_in,
  output logic                            timeout_out
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, sel, pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_any, grant_fire, expire;
  logic [WIDTH-1:0]   dividend, divisor, quo, rem;
  logic               err, tmo;
  logic [CNT_W-1:0]   cnt;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (req_valid_in),
    .last  (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign grant_fire = (state == S_IDLE) && pick_any && !div_busy_in;
  // WAIT lasts at most TIMEOUT_CYCLES cycles: this is the cycle the count hits the limit.
  assign expire     = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_fire) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (div_valid_in || expire) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr      <= IDX_W'(NUM_REQ - 1);
      sel      <= '0;
      dividend <= '0;
      divisor  <= '0;
      quo      <= '0;
      rem      <= '0;
      err      <= 1'b0;
      tmo      <= 1'b0;
      cnt      <= '0;
    end else begin
      if (grant_fire) begin
        ptr      <= pick_idx;
        sel      <= pick_idx;
        dividend <= req_dividend_in[pick_idx];
        divisor  <= req_divisor_in[pick_idx];
      end
      if (state == S_ISSUE)     cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + 1'b1;
      // A result landing on the expiry cycle wins over the timeout.
      if (state == S_WAIT) begin
        if (div_valid_in) begin
          quo <= div_quotient_in;
          rem <= div_remainder_in;
          err <= div_error_in;
        end else if (expire) begin
          quo <= '0;
          rem <= '0;
          err <= 1'b1;
          tmo <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_ready_out  = '0;
    resp_valid_out = '0;
    div_valid_out  = 1'b0;
    if (!rst_in) begin
      if (grant_fire) req_ready_out = pick_grant;
      div_valid_out = (state == S_ISSUE);
      if (state == S_RESP) resp_valid_out[sel] = 1'b1;
    end
  end

  assign resp_quotient_out  = rst_in ? '0 : quo;
  assign resp_remainder_out = rst_in ? '0 : rem;
  assign resp_error_out     = rst_in ? 1'b0 : err;
  assign div_dividend_out   = rst_in ? '0 : dividend;
  assign div_divisor_out    = rst_in ? '0 : divisor;
  assign timeout_out        = rst_in ? 1'b0 : tmo;
endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench: requester/grant model, model divider, decoupled response monitor.
`timescale 1ns/1ps
module tb_div_arbiter;
  localparam int W = 32;
  localparam int N = 4;
  localparam int T = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [N-1:0]        req_valid;
  logic [N-1:0][W-1:0] req_a, req_b;
  logic [N-1:0]        req_ready_out, resp_valid_out;
  logic [W-1:0]        resp_quotient_out, resp_remainder_out;
  logic                resp_error_out;
  logic [W-1:0]        div_dividend_out, div_divisor_out;
  logic                div_valid_out, timeout_out;
  logic [W-1:0]        dq, dr;
  logic                dvalid, derr, dbusy;

  div_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk_in             (clk),
    .rst_in             (rst),
    .req_valid_in       (req_valid),
    .req_dividend_in    (req_a),
    .req_divisor_in     (req_b),
    .req_ready_out      (req_ready_out),
    .resp_valid_out     (resp_valid_out),
    .resp_quotient_out  (resp_quotient_out),
    .resp_remainder_out (resp_remainder_out),
    .resp_error_out     (resp_error_out),
    .div_dividend_out   (div_dividend_out),
    .div_divisor_out    (div_divisor_out),
    .div_valid_out      (div_valid_out),
    .div_quotient_in    (dq),
    .div_remainder_in   (dr),
    .div_valid_in       (dvalid),
    .div_error_in       (derr),
    .div_busy_in        (dbusy),
    .timeout_out        (timeout_out)
  );

  typedef struct {
    int         idx;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic       err;
    logic       tmo;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   lat_q[$];
  int   lat_plan[$];
  int   gorder[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  int   last = N - 1;
  int   left[N];
  bit   pending = 0, rdrop = 0, rand_lat = 0, tmo_model = 0;
  int   pend_age = 0, n_ready = 0, starts = 0;
  int   issue_cyc = 0, late_cyc = 0, grant_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic new_ops(input int i);
    req_a[i] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 1000);
    case ($urandom_range(0, 7))
      0:       req_b[i] = '0;
      1, 2, 3: req_b[i] = $urandom_range(1, 20);
      default: req_b[i] = $urandom;
    endcase
    req_valid[i] = 1'b1;
  endtask

  task automatic request(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input int jobs);
    left[i] = jobs;
    req_a[i] = a;
    req_b[i] = b;
    req_valid[i] = 1'b1;
  endtask

  // Expected response computed from the requester's operands and the chosen divider latency.
  task automatic push_expected(input int win);
    exp_t e;
    int l;
    if (lat_plan.size() > 0) l = lat_plan.pop_front();
    else if (rand_lat)       l = $urandom_range(1, T + 2);
    else                     l = $urandom_range(1, 4);
    e.idx = win;
    e.lat = l;
    e.tmo = 1'b0;
    if (l > T) begin
      e.q = '0; e.r = '0; e.err = 1'b1; e.tmo = 1'b1;
    end else if (req_b[win] == 0) begin
      e.q = '0; e.r = '0; e.err = 1'b1;
    end else begin
      e.q = req_a[win] / req_b[win];
      e.r = req_a[win] % req_b[win];
      e.err = 1'b0;
    end
    exp_q.push_back(e);
    lat_q.push_back(l);
  endtask

  // One clock: sample and check at negedge, then drive requesters after posedge.
  task automatic cycle();
    int win;
    logic [N-1:0] expg;
    logic viol;
    @(negedge clk);
    win = -1;
    expg = '0;
    if (!rst && !pending && (req_valid != 0) && !dbusy) begin
      for (int k = 1; k <= N; k++)
        if (win < 0 && req_valid[(last + k) % N]) win = (last + k) % N;
      expg[win] = 1'b1;
    end
    check("grant", req_ready_out, expg);
    viol = ($countones(req_ready_out) > 1) || ($countones(resp_valid_out) > 1) ||
           ((int'(|req_ready_out) + int'(div_valid_out) + int'(|resp_valid_out)) > 1);
    check("exclusive_pulses", viol, 1'b0);
    if (req_ready_out != 0) n_ready++;
    if (rst) begin
      check("reset_outputs", {req_ready_out, resp_valid_out, resp_quotient_out, resp_remainder_out,
             resp_error_out, div_dividend_out, div_divisor_out, div_valid_out, timeout_out}, '0);
      pending = 0; last = N - 1; tmo_model = 0;
      exp_q.delete(); lat_q.delete();
    end else if (win >= 0) begin
      pending = 1; last = win; pend_age = 0; grant_cyc = cyc;
      gorder.push_back(win);
      push_expected(win);
    end else if (resp_valid_out != 0) begin
      pending = 0;
    end
    if (pending) begin
      pend_age++;
      if (pend_age > T + 20) begin
        check("service_age", pend_age, T + 20);
        pending = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (i == win) begin
        left[i]--;
        if (left[i] > 0) new_ops(i);
        else req_valid[i] = 1'b0;
      end else if (rdrop && left[i] > 0) begin
        if (req_valid[i] && $urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 2) == 0) new_ops(i);
      end
    end
  endtask

  function automatic bit busy_work();
    bit b;
    b = pending || (exp_q.size() > 0) || dbusy;
    for (int i = 0; i < N; i++) if (left[i] > 0) b = 1;
    return b;
  endfunction

  task automatic run_until_idle(input int max);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (busy_work() && n < max);
    check("drain", busy_work(), 1'b0);
  endtask

  // Model divider: consumes the planned latency, busy from start until the result pulse.
  initial begin
    logic [W-1:0] a, b;
    int l;
    dvalid = 0; derr = 0; dbusy = 0; dq = '0; dr = '0;
    forever begin
      @(negedge clk);
      if (div_valid_out) begin
        a = div_dividend_out;
        b = div_divisor_out;
        issue_cyc = cyc;
        starts++;
        l = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
        @(posedge clk); #1;
        dbusy = 1'b1;
        repeat (l - 1) begin @(posedge clk); #1; end
        dvalid = 1'b1;
        derr   = (b == 0);
        dq     = (b == 0) ? '0 : a / b;
        dr     = (b == 0) ? '0 : a % b;
        if (l > T) late_cyc = cyc;
        @(posedge clk); #1;
        dvalid = 1'b0; derr = 1'b0; dbusy = 1'b0;
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a result is presented.
  initial begin
    exp_t e;
    logic [N-1:0] oh;
    int el;
    forever begin
      @(negedge clk);
      if (resp_valid_out != 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", resp_valid_out, '0);
        end else begin
          e = exp_q.pop_front();
          if (e.tmo) tmo_model = 1;
          oh = '0;
          oh[e.idx] = 1'b1;
          el = (e.lat > T) ? T : e.lat;
          check("resp_valid", resp_valid_out, oh);
          check("resp_quotient", resp_quotient_out, e.q);
          check("resp_remainder", resp_remainder_out, e.r);
          check("resp_error", resp_error_out, e.err);
          check("timeout_flag", timeout_out, tmo_model);
          check("resp_latency", cyc - issue_cyc, el + 1);
        end
      end
    end
  end

  initial begin
    int eo[5];
    int s0, n;
    eo = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) left[i] = 0;

    // All four requesters held from reset: round-robin from requester 0.
    request(0, 32'd500, 32'd3, 2);
    request(1, 32'd81, 32'd9, 1);
    request(2, 32'd1234567, 32'd1000, 1);
    request(3, 32'd7, 32'd8, 1);
    repeat (3) cycle();
    rst = 1'b0;
    run_until_idle(400);
    check("rr_order_len", gorder.size(), 5);
    for (int i = 0; i < 5 && i < gorder.size(); i++) check("rr_order", gorder[i], eo[i]);

    // Single request 100/7 from requester 2.
    n_ready = 0;
    s0 = starts;
    lat_plan.push_back(3);
    request(2, 32'd100, 32'd7, 1);
    run_until_idle(100);
    check("single_ready_pulses", n_ready, 1);
    check("single_div_starts", starts - s0, 1);

    // Divide by zero from requester 1.
    lat_plan.push_back(2);
    request(1, 32'd999, 32'd0, 1);
    run_until_idle(100);

    // Result arriving exactly on the expiry cycle is a normal result.
    lat_plan.push_back(T);
    request(3, 32'd1000, 32'd33, 1);
    run_until_idle(100);

    // Divider never answers in time; late pulse ignored, next grant waits for busy low.
    lat_plan.push_back(T + 4);
    lat_plan.push_back(2);
    request(0, 32'd4000, 32'd5, 1);
    request(1, 32'd61, 32'd6, 1);
    run_until_idle(200);
    check("grant_after_busy_low", grant_cyc > late_cyc, 1'b1);
    check("timeout_sticky", timeout_out, 1'b1);

    // Reset during WAIT abandons the transaction.
    lat_plan.push_back(8);
    lat_plan.push_back(3);
    request(2, 32'd5000, 32'd9, 1);
    n = 0;
    s0 = starts;
    while (starts == s0 && n < 50) begin cycle(); n++; end
    check("reset_case_issued", starts - s0, 1);
    repeat (2) cycle();
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    check("timeout_cleared", timeout_out, 1'b0);
    request(2, 32'd777, 32'd5, 1);
    run_until_idle(200);

    // Randomized traffic with request drops, zero divisors and timeouts.
    rdrop = 1;
    rand_lat = 1;
    for (int i = 0; i < N; i++) begin
      left[i] = $urandom_range(4, 8);
      new_ops(i);
    end
    run_until_idle(4000);
    rdrop = 0;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
